swu_rd_control: RTL

Read-side controller of the sliding-window unit (SWU) line buffer. It sits downstream of the buffer write controller.
- Walks kernel windows over a square input feature map and issues read addresses plus enables to the buffer RAM.
- Presents the RAM output as a valid/ready stream, one pixel word per beat, with window and frame markers.
- Reports to the write side which buffer region is still needed, and pulses rd_done at end of frame so the writer restarts.

---
 rtl/swu_rd_control.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/swu_rd_control.sv
// Read-side controller of the SWU line buffer: walks kernel windows over a
// square feature map, issues buffer RAM reads, and streams the read data
// out with window/frame markers. Reports the lowest still-needed pixel
// index to the writer and pulses rd_done once the frame has drained.
module swu_rd_control #(
  parameter  int unsigned IFM_DIM      = 4,
  parameter  int unsigned K            = 3,
  parameter  int unsigned STRIDE       = 1,
  parameter  int unsigned BUFFER_DEPTH = 16,
  localparam int unsigned IDXW         = $clog2(IFM_DIM*IFM_DIM + 1),
  localparam int unsigned AW           = $clog2(BUFFER_DEPTH)
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [IDXW-1:0] wr_count,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            out_frame_last,
  output logic [IDXW-1:0] rd_base,
  output logic            rd_done
);

  localparam int unsigned OUT_DIM = (IFM_DIM - K) / STRIDE + 1;
  localparam int unsigned CW      = $clog2(K + 1);
  localparam int unsigned OW      = $clog2(OUT_DIM + 1);
  localparam int unsigned AW1     = AW + 1;

  localparam logic [CW-1:0]   KMAX     = CW'(K - 1);
  localparam logic [OW-1:0]   OMAX     = OW'(OUT_DIM - 1);
  localparam logic [AW:0]     DEPTH_C  = AW1'(BUFFER_DEPTH);
  // Pointer steps pre-reduced modulo the depth so one subtraction suffices.
  localparam logic [AW:0]     INC_COL  = AW1'(1 % BUFFER_DEPTH);
  localparam logic [AW:0]     INC_ROW  = AW1'(IFM_DIM % BUFFER_DEPTH);
  localparam logic [AW:0]     INC_WIN  = AW1'(STRIDE % BUFFER_DEPTH);
  localparam logic [AW:0]     INC_LINE = AW1'((STRIDE * IFM_DIM) % BUFFER_DEPTH);
  localparam logic [IDXW-1:0] NEED_OFF = IDXW'((K - 1) * IFM_DIM + K - 1);
  localparam logic [IDXW-1:0] STEP_OX  = IDXW'(STRIDE);
  localparam logic [IDXW-1:0] STEP_OY  = IDXW'(STRIDE * IFM_DIM);

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + b;
    if (s >= DEPTH_C) s = s - DEPTH_C;
    return s[AW-1:0];
  endfunction

  logic [CW-1:0]   kx_q, kx_d, ky_q, ky_d;
  logic [OW-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [AW-1:0]   addr_q, addr_d, row_addr_q, row_addr_d;
  logic [AW-1:0]   win_addr_q, win_addr_d, line_addr_q, line_addr_d;
  logic [IDXW-1:0] ox_off_q, ox_off_d, rd_base_q, rd_base_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic            out_flast_q, out_flast_d, rd_done_q, rd_done_d;
  logic            pend_q, pend_d;
  logic [IDXW-1:0] need;
  logic            win_end, frame_end, avail, issue;

  // Window availability and read issue decision.
  always_comb begin
    need      = rd_base_q + ox_off_q + NEED_OFF;
    win_end   = (kx_q == KMAX) && (ky_q == KMAX);
    frame_end = win_end && (ox_q == OMAX) && (oy_q == OMAX);
    // A started window is never re-qualified against wr_count.
    avail     = (kx_q != '0) || (ky_q != '0) || (wr_count > need);
    issue     = aresetn && avail && (!out_valid_q || out_ready) && !pend_q;
  end

  // Counter walk with incrementally wrapped row/window/line pointers.
  always_comb begin
    kx_d        = kx_q;
    ky_d        = ky_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    addr_d      = addr_q;
    row_addr_d  = row_addr_q;
    win_addr_d  = win_addr_q;
    line_addr_d = line_addr_q;
    ox_off_d    = ox_off_q;
    rd_base_d   = rd_base_q;
    pend_d      = pend_q;
    if (issue) begin
      if (kx_q != KMAX) begin
        kx_d   = kx_q + CW'(1);
        addr_d = wrap_add(addr_q, INC_COL);
      end else begin
        kx_d = '0;
        if (ky_q != KMAX) begin
          ky_d       = ky_q + CW'(1);
          row_addr_d = wrap_add(row_addr_q, INC_ROW);
          addr_d     = row_addr_d;
        end else begin
          ky_d = '0;
          if (ox_q != OMAX) begin
            ox_d       = ox_q + OW'(1);
            ox_off_d   = ox_off_q + STEP_OX;
            win_addr_d = wrap_add(win_addr_q, INC_WIN);
            row_addr_d = win_addr_d;
            addr_d     = win_addr_d;
          end else begin
            ox_d     = '0;
            ox_off_d = '0;
            if (oy_q != OMAX) begin
              oy_d        = oy_q + OW'(1);
              rd_base_d   = rd_base_q + STEP_OY;
              line_addr_d = wrap_add(line_addr_q, INC_LINE);
              win_addr_d  = line_addr_d;
              row_addr_d  = line_addr_d;
              addr_d      = line_addr_d;
            end else begin
              oy_d        = '0;
              rd_base_d   = '0;
              line_addr_d = '0;
              win_addr_d  = '0;
              row_addr_d  = '0;
              addr_d      = '0;
              pend_d      = 1'b1;
            end
          end
        end
      end
    end else if (rd_done_q) begin
      // Held through the rd_done cycle so stale wr_count cannot start a read.
      pend_d = 1'b0;
    end
  end

  // Output stage: flags follow the issued element, hold under backpressure.
  always_comb begin
    out_valid_d = issue || (out_valid_q && !out_ready);
    out_last_d  = out_last_q;
    out_flast_d = out_flast_q;
    if (issue) begin
      out_last_d  = win_end;
      out_flast_d = frame_end;
    end else if (out_ready) begin
      out_last_d  = 1'b0;
      out_flast_d = 1'b0;
    end
    rd_done_d = out_valid_q && out_ready && out_flast_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      kx_q        <= '0;
      ky_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      addr_q      <= '0;
      row_addr_q  <= '0;
      win_addr_q  <= '0;
      line_addr_q <= '0;
      ox_off_q    <= '0;
      rd_base_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_flast_q <= 1'b0;
      rd_done_q   <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      addr_q      <= addr_d;
      row_addr_q  <= row_addr_d;
      win_addr_q  <= win_addr_d;
      line_addr_q <= line_addr_d;
      ox_off_q    <= ox_off_d;
      rd_base_q   <= rd_base_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_flast_q <= out_flast_d;
      rd_done_q   <= rd_done_d;
      pend_q      <= pend_d;
    end
  end

  assign rd_en          = issue;
  assign rd_addr        = addr_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign out_frame_last = out_flast_q;
  assign rd_base        = rd_base_q;
  assign rd_done        = rd_done_q;

endmodule
